// File: rtl/draw_pkg.sv
// Shared opcodes and FSM state encoding for the draw command scheduler.
package draw_pkg;
  localparam logic [3:0] OP_PIXEL = 4'h0;
  localparam logic [3:0] OP_RECT  = 4'h1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_DATA,
    ST_DISPATCH,
    ST_RUN,
    ST_DROP
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_PIXEL) || (op == OP_RECT);
  endfunction
endpackage

// File: rtl/draw_cmd_scheduler_if.sv
// Command FIFO read port: the scheduler pops, the FIFO answers one cycle later.
interface draw_cmd_scheduler_if #(parameter int CMD_WIDTH = 32);
  logic                 ff_empty;
  logic                 ff_rden;
  logic [CMD_WIDTH-1:0] ff_rdat;
  logic                 ff_rvld;

  modport master (output ff_rden, input ff_empty, ff_rdat, ff_rvld);
  modport slave  (input ff_rden, output ff_empty, ff_rdat, ff_rvld);
endinterface

// File: rtl/ram_wr_mux.sv
// Two-input VGA RAM write mux; all-zero output unless enabled.
module ram_wr_mux #(
  parameter int ADDR_WIDTH  = 19,
  parameter int COLOR_WIDTH = 8
) (
  input  logic                   en,
  input  logic                   sel,
  input  logic [ADDR_WIDTH-1:0]  a_addr,
  input  logic [COLOR_WIDTH-1:0] a_data,
  input  logic                   a_wren,
  input  logic [ADDR_WIDTH-1:0]  b_addr,
  input  logic [COLOR_WIDTH-1:0] b_data,
  input  logic                   b_wren,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic [COLOR_WIDTH-1:0] data,
  output logic                   wren
);
  always_comb begin
    addr = '0;
    data = '0;
    wren = 1'b0;
    if (en) begin
      if (sel) begin
        addr = b_addr;
        data = b_data;
        wren = b_wren;
      end else begin
        addr = a_addr;
        data = a_data;
        wren = a_wren;
      end
    end
  end
endmodule

// File: rtl/draw_cmd_scheduler.sv
// Pops draw commands one at a time, starts the matching engine, waits for
// done or timeout, and routes that engine's RAM writes to the VGA port.
module draw_cmd_scheduler
  import draw_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 19,
  parameter int          COLOR_WIDTH = 8,
  parameter int          CMD_WIDTH   = 32,
  parameter logic [23:0] TIMEOUT_MAX = 24'd16777215
) (
  input  logic                   clk,
  input  logic                   rst,
  draw_cmd_scheduler_if.master   ff,
  output logic [CMD_WIDTH-5:0]   cmd_args,
  output logic                   pixel_vld,
  output logic                   rect_vld,
  input  logic                   pixel_done,
  input  logic                   rect_done,
  input  logic [ADDR_WIDTH-1:0]  pixel_addr,
  input  logic [COLOR_WIDTH-1:0] pixel_data,
  input  logic                   pixel_wren,
  input  logic [ADDR_WIDTH-1:0]  rect_addr,
  input  logic [COLOR_WIDTH-1:0] rect_data,
  input  logic                   rect_wren,
  output logic [ADDR_WIDTH-1:0]  oaddr,
  output logic [COLOR_WIDTH-1:0] odata,
  output logic                   owren,
  output logic                   busy,
  output logic [7:0]             err_cnt,
  output logic                   timeout_flag
);
  state_t      state;
  logic        armed;
  logic        sel_rect;
  logic [23:0] tcnt;
  logic [3:0]  op;
  logic        sel_done;

  assign op       = ff.ff_rdat[CMD_WIDTH-1 -: 4];
  assign sel_done = sel_rect ? rect_done : pixel_done;

  // armed holds off the first fetch until the second edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      armed        <= 1'b0;
      sel_rect     <= 1'b0;
      tcnt         <= '0;
      ff.ff_rden   <= 1'b0;
      cmd_args     <= '0;
      pixel_vld    <= 1'b0;
      rect_vld     <= 1'b0;
      busy         <= 1'b0;
      err_cnt      <= '0;
      timeout_flag <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (armed && !ff.ff_empty) begin
            state      <= ST_FETCH;
            ff.ff_rden <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_FETCH: begin
          ff.ff_rden <= 1'b0;
          state      <= ST_WAIT_DATA;
        end
        ST_WAIT_DATA: begin
          if (ff.ff_rvld) begin
            cmd_args <= ff.ff_rdat[CMD_WIDTH-5:0];
            sel_rect <= (op == OP_RECT);
            if (op_legal(op)) begin
              state     <= ST_DISPATCH;
              pixel_vld <= (op == OP_PIXEL);
              rect_vld  <= (op == OP_RECT);
            end else begin
              state <= ST_DROP;
            end
          end
        end
        ST_DISPATCH: begin
          pixel_vld <= 1'b0;
          rect_vld  <= 1'b0;
          tcnt      <= '0;
          state     <= ST_RUN;
        end
        ST_RUN: begin
          // done wins over a timeout expiring in the same cycle
          if (sel_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (tcnt == TIMEOUT_MAX - 24'd1) begin
            timeout_flag <= 1'b1;
            state        <= ST_IDLE;
            busy         <= 1'b0;
          end else begin
            tcnt <= tcnt + 24'd1;
          end
        end
        ST_DROP: begin
          if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  ram_wr_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .COLOR_WIDTH(COLOR_WIDTH)
  ) u_wr_mux (
    .en    ((state == ST_DISPATCH) || (state == ST_RUN)),
    .sel   (sel_rect),
    .a_addr(pixel_addr),
    .a_data(pixel_data),
    .a_wren(pixel_wren),
    .b_addr(rect_addr),
    .b_data(rect_data),
    .b_wren(rect_wren),
    .addr  (oaddr),
    .data  (odata),
    .wren  (owren)
  );
endmodule

// File: tb/tb_draw_cmd_scheduler.sv
// Randomized bench: FIFO model feeds commands, engines are driven by the tasks.
module tb_draw_cmd_scheduler;
  localparam int          AW   = 19;
  localparam int          CW   = 8;
  localparam int          DW   = 32;
  localparam logic [23:0] TMAX = 24'd16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  draw_cmd_scheduler_if #(.CMD_WIDTH(DW)) ff_if ();

  logic [DW-5:0] cmd_args;
  logic          pixel_vld, rect_vld, busy, timeout_flag, owren;
  logic          pixel_done = 1'b0, rect_done = 1'b0;
  logic [AW-1:0] pixel_addr = '0, rect_addr = '0, oaddr;
  logic [CW-1:0] pixel_data = '0, rect_data = '0, odata;
  logic          pixel_wren = 1'b0, rect_wren = 1'b0;
  logic [7:0]    err_cnt;

  draw_cmd_scheduler #(
    .ADDR_WIDTH(AW), .COLOR_WIDTH(CW), .CMD_WIDTH(DW), .TIMEOUT_MAX(TMAX)
  ) dut (
    .clk(clk), .rst(rst), .ff(ff_if),
    .cmd_args(cmd_args), .pixel_vld(pixel_vld), .rect_vld(rect_vld),
    .pixel_done(pixel_done), .rect_done(rect_done),
    .pixel_addr(pixel_addr), .pixel_data(pixel_data), .pixel_wren(pixel_wren),
    .rect_addr(rect_addr), .rect_data(rect_data), .rect_wren(rect_wren),
    .oaddr(oaddr), .odata(odata), .owren(owren),
    .busy(busy), .err_cnt(err_cnt), .timeout_flag(timeout_flag)
  );

  // FIFO model: data valid one cycle after the read strobe
  logic [DW-1:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign ff_if.ff_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (rst) ff_if.ff_rvld <= 1'b0;
    else begin
      ff_if.ff_rvld <= 1'b0;
      if (ff_if.ff_rden && (wr_ptr != rd_ptr)) begin
        ff_if.ff_rdat <= fifo_mem[rd_ptr];
        ff_if.ff_rvld <= 1'b1;
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  int pix_starts = 0, rect_starts = 0, rden_pulses = 0, viol = 0;
  logic pv_q = 1'b0, rv_q = 1'b0;
  always @(posedge clk) begin
    pv_q <= pixel_vld;
    rv_q <= rect_vld;
    if (!rst) begin
      if (pixel_vld) pix_starts <= pix_starts + 1;
      if (rect_vld) rect_starts <= rect_starts + 1;
      if (ff_if.ff_rden) rden_pulses <= rden_pulses + 1;
      if ((pixel_vld && rect_vld) || (pixel_vld && pv_q) || (rect_vld && rv_q) ||
          (ff_if.ff_rden && (pixel_vld || rect_vld)))
        viol <= viol + 1;
    end
  end

  int errors = 0, checks = 0;
  int n_illegal = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [DW-1:0] c);
    fifo_mem[wr_ptr] = c;
    wr_ptr = wr_ptr + 1;
  endtask

  // waits (bounded) for a start pulse; which=-1 when none arrives
  task automatic wait_start(output int which, output logic [DW-5:0] args);
    which = -1;
    args  = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pixel_vld) begin which = 0; args = cmd_args; break; end
      if (rect_vld) begin which = 1; args = cmd_args; break; end
    end
  endtask

  task automatic pulse_done(input int which);
    if (which == 1) rect_done = 1'b1; else pixel_done = 1'b1;
    tick();
    pixel_done = 1'b0;
    rect_done  = 1'b0;
  endtask

  task automatic rand_writes();
    pixel_addr = AW'($urandom); pixel_data = CW'($urandom); pixel_wren = 1'($urandom);
    rect_addr  = AW'($urandom); rect_data  = CW'($urandom); rect_wren  = 1'($urandom);
  endtask

  task automatic clear_writes();
    pixel_addr = '0; pixel_data = '0; pixel_wren = 1'b0;
    rect_addr  = '0; rect_data  = '0; rect_wren  = 1'b0;
  endtask

  task automatic test_reset();
    logic [DW-1:0] c;
    int which;
    logic [DW-5:0] args;
    rst = 1'b1;
    pixel_wren = 1'b1; rect_wren = 1'b1; pixel_addr = AW'($urandom); pixel_data = 8'hA5;
    c = {4'h0, 28'($urandom)};
    push(c);
    repeat (3) tick();
    checks++; if ({ff_if.ff_rden, pixel_vld, rect_vld, busy, timeout_flag, owren} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {ff_if.ff_rden, pixel_vld, rect_vld, busy, timeout_flag, owren}); end
    checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0h want 0", err_cnt); end
    checks++; if (cmd_args !== '0) begin errors++; $display("FAIL reset_cmd_args: got %0h want 0", cmd_args); end
    checks++; if ({oaddr, odata} !== '0) begin errors++; $display("FAIL reset_wr: got %0h/%0h want 0", oaddr, odata); end
    clear_writes();
    rst = 1'b0;
    tick();
    checks++; if (ff_if.ff_rden !== 1'b0) begin errors++; $display("FAIL rden_first_edge: got %b want 0", ff_if.ff_rden); end
    tick();
    checks++; if (ff_if.ff_rden !== 1'b1) begin errors++; $display("FAIL rden_second_edge: got %b want 1", ff_if.ff_rden); end
    wait_start(which, args);
    checks++; if (which !== 0 || args !== c[DW-5:0]) begin
      errors++; $display("FAIL reset_first_cmd: got %0d/%0h want 0/%0h", which, args, c[DW-5:0]); end
    tick();
    pulse_done(0);
  endtask

  task automatic test_pixel();
    logic [DW-1:0] c;
    c = {4'h0, 5'd3, 5'd4, 8'h0f, 10'b0};
    push(c);
    tick();
    checks++; if (ff_if.ff_rden !== 1'b1) begin errors++; $display("FAIL pix_rden: got %b want 1", ff_if.ff_rden); end
    tick();
    checks++; if (ff_if.ff_rden !== 1'b0) begin errors++; $display("FAIL pix_rden_once: got %b want 0", ff_if.ff_rden); end
    tick();
    checks++; if ({pixel_vld, rect_vld, busy} !== 3'b101) begin
      errors++; $display("FAIL pix_start: got %b want 101", {pixel_vld, rect_vld, busy}); end
    checks++; if (cmd_args[27:18] !== {5'd3, 5'd4} || cmd_args !== c[DW-5:0]) begin
      errors++; $display("FAIL pix_args: got %0h want %0h", cmd_args, c[DW-5:0]); end
    tick();
    checks++; if ({pixel_vld, busy} !== 2'b01) begin errors++; $display("FAIL pix_pulse_len: got %b want 01", {pixel_vld, busy}); end
    for (int i = 0; i < 5; i++) begin
      rand_writes();
      #1;
      checks++; if ({oaddr, odata, owren} !== {pixel_addr, pixel_data, pixel_wren}) begin
        errors++; $display("FAIL pix_fwd: got %0h/%0h/%b want %0h/%0h/%b", oaddr, odata, owren, pixel_addr, pixel_data, pixel_wren); end
      tick();
    end
    pulse_done(1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pix_ignore_rect_done: busy got %b want 1", busy); end
    pixel_wren = 1'b1; pixel_addr = AW'($urandom | 1);
    pulse_done(0);
    #1;
    checks++; if ({busy, owren, oaddr, odata} !== '0) begin
      errors++; $display("FAIL pix_idle: busy %b wr %b/%0h/%0h want all 0", busy, owren, oaddr, odata); end
    clear_writes();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] cr, cp;
    int which;
    logic [DW-5:0] args;
    int bad_fwd = 0, bad_rden = 0;
    cr = {4'h1, 28'($urandom)};
    cp = {4'h0, 28'($urandom)};
    push(cr);
    push(cp);
    wait_start(which, args);
    checks++; if (which !== 1 || args !== cr[DW-5:0]) begin
      errors++; $display("FAIL b2b_rect_start: got %0d/%0h want 1/%0h", which, args, cr[DW-5:0]); end
    tick();
    for (int i = 0; i < 6; i++) begin
      rand_writes();
      pixel_wren = 1'b1;
      #1;
      if ({oaddr, odata, owren} !== {rect_addr, rect_data, rect_wren}) bad_fwd++;
      if (ff_if.ff_rden !== 1'b0) bad_rden++;
      tick();
    end
    checks++; if (bad_fwd != 0) begin errors++; $display("FAIL b2b_rect_fwd: got %0d bad cycles want 0", bad_fwd); end
    checks++; if (bad_rden != 0) begin errors++; $display("FAIL b2b_rden_in_run: got %0d cycles want 0", bad_rden); end
    clear_writes();
    pulse_done(1);
    tick();
    checks++; if (ff_if.ff_rden !== 1'b1) begin errors++; $display("FAIL b2b_second_rden: got %b want 1", ff_if.ff_rden); end
    wait_start(which, args);
    checks++; if (which !== 0 || args !== cp[DW-5:0]) begin
      errors++; $display("FAIL b2b_pixel_start: got %0d/%0h want 0/%0h", which, args, cp[DW-5:0]); end
    tick();
    pulse_done(0);
  endtask

  task automatic test_simultaneous();
    int which;
    logic [DW-5:0] args;
    push({4'h0, 28'($urandom)});
    wait_start(which, args);
    tick();
    repeat (int'(TMAX) - 1) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL simul_busy: got %b want 1", busy); end
    pulse_done(0);
    checks++; if ({busy, timeout_flag} !== 2'b00) begin
      errors++; $display("FAIL simul_timeout: got busy/tmo %b want 00", {busy, timeout_flag}); end
  endtask

  task automatic test_timeout();
    int which;
    logic [DW-5:0] args;
    int early = 0;
    push({4'h0, 28'($urandom)});
    wait_start(which, args);
    tick();
    for (int i = 0; i < int'(TMAX) - 1; i++) begin
      tick();
      if (timeout_flag !== 1'b0 || busy !== 1'b1) early++;
    end
    checks++; if (early != 0) begin errors++; $display("FAIL tmo_early: got %0d bad cycles want 0", early); end
    tick();
    checks++; if ({timeout_flag, busy} !== 2'b10) begin
      errors++; $display("FAIL tmo_expire: got tmo/busy %b want 10", {timeout_flag, busy}); end
    push({4'h1, 28'($urandom)});
    wait_start(which, args);
    checks++; if (which !== 1) begin errors++; $display("FAIL tmo_next_cmd: got %0d want 1", which); end
    tick();
    pulse_done(1);
    checks++; if ({timeout_flag, busy} !== 2'b10) begin
      errors++; $display("FAIL tmo_sticky: got tmo/busy %b want 10", {timeout_flag, busy}); end
  endtask

  task automatic test_illegal();
    int s0, exp, k;
    s0 = pix_starts + rect_starts;
    for (int i = 0; i < 3; i++) begin
      push({4'h7, 28'($urandom)});
      n_illegal++;
      repeat (5) tick();
      checks++; if (busy !== 1'b0 || err_cnt !== 8'(n_illegal)) begin
        errors++; $display("FAIL illegal_%0d: got busy %b err %0d want 0/%0d", i, busy, err_cnt, n_illegal); end
    end
    checks++; if (pix_starts + rect_starts !== s0) begin
      errors++; $display("FAIL illegal_no_vld: got %0d starts want %0d", pix_starts + rect_starts, s0); end
    for (int i = 0; i < 300; i++) push({4'($urandom_range(2, 15)), 28'($urandom)});
    n_illegal += 300;
    k = 0;
    tick();
    while (!(ff_if.ff_empty && !busy) && k < 3000) begin tick(); k++; end
    checks++; if (k >= 3000) begin errors++; $display("FAIL sat_drain: got timeout want drained"); end
    exp = (n_illegal > 255) ? 255 : n_illegal;
    checks++; if (err_cnt !== 8'(exp)) begin errors++; $display("FAIL sat_err_cnt: got %0d want %0d", err_cnt, exp); end
    checks++; if (pix_starts + rect_starts !== s0) begin
      errors++; $display("FAIL sat_no_vld: got %0d starts want %0d", pix_starts + rect_starts, s0); end
  endtask

  task automatic test_reset_mid_run();
    int which, rs, rd;
    logic [DW-5:0] args;
    push({4'h1, 28'($urandom)});
    wait_start(which, args);
    tick();
    rect_wren = 1'b1; rect_addr = AW'($urandom | 1); rect_data = CW'($urandom | 1);
    #1;
    checks++; if (owren !== 1'b1) begin errors++; $display("FAIL rmr_active: owren got %b want 1", owren); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({ff_if.ff_rden, pixel_vld, rect_vld, busy, timeout_flag, owren} !== 6'b0) begin
      errors++; $display("FAIL rmr_ctrl: got %b want 000000", {ff_if.ff_rden, pixel_vld, rect_vld, busy, timeout_flag, owren}); end
    checks++; if ({err_cnt, cmd_args, oaddr, odata} !== '0) begin
      errors++; $display("FAIL rmr_data: err %0h args %0h wr %0h/%0h want 0", err_cnt, cmd_args, oaddr, odata); end
    tick(); tick();
    rst = 1'b0;
    rs = rect_starts; rd = rden_pulses;
    repeat (10) tick();
    checks++; if (rect_starts !== rs || rden_pulses !== rd || busy !== 1'b0) begin
      errors++; $display("FAIL rmr_no_replay: got rect %0d rden %0d busy %b want %0d %0d 0", rect_starts, rden_pulses, busy, rs, rd); end
    clear_writes();
    push({4'h0, 28'($urandom)});
    wait_start(which, args);
    checks++; if (which !== 0) begin errors++; $display("FAIL rmr_new_cmd: got %0d want 0", which); end
    tick();
    pulse_done(0);
  endtask

  initial begin
    test_reset();
    test_pixel();
    test_back_to_back();
    test_simultaneous();
    test_timeout();
    test_illegal();
    test_reset_mid_run();
    checks++; if (viol != 0) begin errors++; $display("FAIL pulse_rules: got %0d violations want 0", viol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
